// File: rtl/uart_pkg.sv
// Shared constants, receiver state encoding and baud divider helper for the UART receive path.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_t;

    // Rounded clocks per oversample tick, never below one.
    function automatic int tick_div(input int clk_hz, input int baud);
        int d;
        d = (clk_hz + (baud * OVERSAMPLE) / 2) / (baud * OVERSAMPLE);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Read-side bundle of the UART receiver: FIFO head handshake, occupancy and sticky error flags.
interface uart_rx_fifo_if
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_BITS-1:0] rd_data;
    logic                 rd_valid;
    logic                 rd_ready;
    logic                 frame_err;
    logic                 overrun;
    logic                 err_clr;
    logic [CNT_W-1:0]     fifo_count;

    modport master (
        output rd_data, rd_valid, frame_err, overrun, fifo_count,
        input  rd_ready, err_clr
    );

    modport slave (
        input  rd_data, rd_valid, frame_err, overrun, fifo_count,
        output rd_ready, err_clr
    );
endinterface

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Small circular byte buffer with wrap-bit pointers; a pop frees room for a same-cycle push even when full.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Head reads as zero while empty so every output is clean out of reset.
    assign head  = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];
    assign count = count_reg;

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling, start-bit validation, sticky errors and a byte FIFO.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQUENCY = 50000000,
    parameter int BAUD_RATE     = 115200,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           rx,
    uart_rx_fifo_if.master rd_if
);
    localparam int TICK_DIV = tick_div(CLK_FREQUENCY, BAUD_RATE);
    localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICK_DIV - 1);
    localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;

    localparam logic [2:0] S_IDLE      = IDLE;
    localparam logic [2:0] S_START     = START;
    localparam logic [2:0] S_DATA      = DATA;
    localparam logic [2:0] S_STOP      = STOP;
    localparam logic [2:0] S_WAIT_HIGH = WAIT_HIGH;

    localparam logic [3:0] MID_SAMPLE = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] END_SAMPLE = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] LAST_BIT   = 3'(DATA_BITS - 1);

    logic                  rx_meta_reg, rx_s_reg;
    logic [TICK_W-1:0]     tick_cnt_reg;
    logic                  tick;
    logic [2:0]            state_reg, state_next;
    logic [3:0]            sample_cnt_reg, sample_cnt_next;
    logic [2:0]            bit_cnt_reg, bit_cnt_next;
    logic [DATA_BITS-1:0]  shift_reg, shift_next;
    logic                  data_sample;
    logic                  push;
    logic                  set_frame, set_over;
    logic                  frame_err_reg, overrun_reg;
    logic                  fifo_full, fifo_empty;
    logic                  accept;
    logic [DATA_BITS-1:0]  fifo_head;
    logic [CNT_W-1:0]      fifo_count;

    // Flops idle high so reset never looks like a start edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rx_s_reg    <= rx_meta_reg;
        end
    end

    // Held at zero while idle so the tick phase starts at the falling edge.
    assign tick = (state_reg != S_IDLE) && (tick_cnt_reg == TICK_MAX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt_reg <= '0;
        end else if (state_reg == S_IDLE || tick) begin
            tick_cnt_reg <= '0;
        end else begin
            tick_cnt_reg <= tick_cnt_reg + TICK_W'(1);
        end
    end

    // A pop in the same cycle frees a slot for the incoming byte.
    assign accept = !fifo_full || (rd_if.rd_ready && !fifo_empty);

    always_comb begin
        state_next      = state_reg;
        sample_cnt_next = sample_cnt_reg;
        bit_cnt_next    = bit_cnt_reg;
        data_sample     = 1'b0;
        push            = 1'b0;
        set_frame       = 1'b0;
        set_over        = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (!rx_s_reg) begin
                    state_next      = S_START;
                    sample_cnt_next = '0;
                    bit_cnt_next    = '0;
                end
            end
            S_START: begin
                if (tick) begin
                    sample_cnt_next = sample_cnt_reg + 4'd1;
                    if (sample_cnt_reg == MID_SAMPLE) begin
                        state_next      = rx_s_reg ? S_IDLE : S_DATA;
                        sample_cnt_next = '0;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    sample_cnt_next = sample_cnt_reg + 4'd1;
                    if (sample_cnt_reg == END_SAMPLE) begin
                        data_sample  = 1'b1;
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == LAST_BIT) state_next = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    sample_cnt_next = sample_cnt_reg + 4'd1;
                    if (sample_cnt_reg == END_SAMPLE) begin
                        if (rx_s_reg) begin
                            push       = accept;
                            set_over   = !accept;
                            state_next = S_IDLE;
                        end else begin
                            set_frame  = 1'b1;
                            state_next = S_WAIT_HIGH;
                        end
                    end
                end
            end
            S_WAIT_HIGH: begin
                if (rx_s_reg) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < DATA_BITS; gi++) begin : g_shift
            assign shift_next[gi] = (data_sample && bit_cnt_reg == 3'(gi)) ? rx_s_reg
                                                                             : shift_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= S_IDLE;
            sample_cnt_reg <= '0;
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            sample_cnt_reg <= sample_cnt_next;
            bit_cnt_reg    <= bit_cnt_next;
            shift_reg      <= shift_next;
        end
    end

    // Setting wins over a simultaneous clear so no error can be lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            if (set_frame)          frame_err_reg <= 1'b1;
            else if (rd_if.err_clr) frame_err_reg <= 1'b0;
            if (set_over)           overrun_reg   <= 1'b1;
            else if (rd_if.err_clr) overrun_reg   <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (shift_reg),
        .pop       (rd_if.rd_ready),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign rd_if.rd_data    = fifo_head;
    assign rd_if.rd_valid   = !fifo_empty;
    assign rd_if.fifo_count = fifo_count;
    assign rd_if.frame_err  = frame_err_reg;
    assign rd_if.overrun    = overrun_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 16 clocks per bit: reception, back-to-back, glitch, errors, full FIFO, reset.
module tb_uart_rx_fifo;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic rx = 1'b1;

    uart_rx_fifo_if #(.FIFO_DEPTH(4)) rd_if ();

    uart_rx_fifo #(
        .CLK_FREQUENCY (1600000),
        .BAUD_RATE     (100000),
        .FIFO_DEPTH    (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .rx      (rx),
        .rd_if   (rd_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] pop_q [$];

    always @(negedge clk) begin
        if (rd_if.rd_valid && rd_if.rd_ready) begin
            pop_q.push_back(rd_if.rd_data);
            $display("pop  0x%02h", rd_if.rd_data);
        end
    end

    // Called and returns at posedge+1; 160 clocks per frame. stop_low>0 holds the stop bit low that long.
    task automatic send_frame(input logic [7:0] b, input int stop_low);
        $display("send 0x%02h stop_low=%0d", b, stop_low);
        rx = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (16) @(posedge clk);
            #1;
        end
        if (stop_low > 0) begin
            rx = 1'b0;
            repeat (stop_low) @(posedge clk);
            #1;
        end
        rx = 1'b1;
        repeat (16) @(posedge clk);
        #1;
    endtask

    task automatic pop_one(output logic [7:0] b);
        b = rd_if.rd_data;
        rd_if.rd_ready = 1'b1;
        @(posedge clk);
        #1;
        rd_if.rd_ready = 1'b0;
    endtask

    task automatic pulse_err_clr();
        rd_if.err_clr = 1'b1;
        @(posedge clk);
        #1;
        rd_if.err_clr = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (rd_if.rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got %b expected 0", rd_if.rd_valid); end
        n_checks++; if (rd_if.rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data got %h expected 00", rd_if.rd_data); end
        n_checks++; if (rd_if.fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d expected 0", rd_if.fifo_count); end
        n_checks++; if ({rd_if.frame_err, rd_if.overrun} !== 2'b00) begin n_fail++; $display("FAIL reset_errs got %b expected 00", {rd_if.frame_err, rd_if.overrun}); end
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        int lat;
        logic [7:0] b;
        lat = -1;
        fork
            send_frame(8'h55, 0);
            begin
                for (int n = 1; n <= 400; n++) begin
                    @(posedge clk);
                    #1;
                    if (rd_if.rd_valid) begin lat = n; break; end
                end
            end
        join
        n_checks++; if (lat !== 155) begin n_fail++; $display("FAIL single_latency got %0d expected 155", lat); end
        n_checks++; if (rd_if.rd_data !== 8'h55) begin n_fail++; $display("FAIL single_data got %h expected 55", rd_if.rd_data); end
        n_checks++; if (rd_if.fifo_count !== 3'd1) begin n_fail++; $display("FAIL single_count got %0d expected 1", rd_if.fifo_count); end
        n_checks++; if ({rd_if.frame_err, rd_if.overrun} !== 2'b00) begin n_fail++; $display("FAIL single_errs got %b expected 00", {rd_if.frame_err, rd_if.overrun}); end
        pop_one(b);
        n_checks++; if (rd_if.fifo_count !== 3'd0) begin n_fail++; $display("FAIL single_drain got %0d expected 0", rd_if.fifo_count); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b [3];
        exp_b[0] = 8'hA3; exp_b[1] = 8'h00; exp_b[2] = 8'hFF;
        pop_q.delete();
        rd_if.rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) send_frame(exp_b[i], 0);
        repeat (5) @(posedge clk);
        #1;
        rd_if.rd_ready = 1'b0;
        n_checks++; if (pop_q.size() !== 3) begin n_fail++; $display("FAIL b2b_pops got %0d expected 3", pop_q.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < pop_q.size()) begin
                n_checks++; if (pop_q[i] !== exp_b[i]) begin n_fail++; $display("FAIL b2b_data%0d got %h expected %h", i, pop_q[i], exp_b[i]); end
            end
        end
        n_checks++; if (rd_if.fifo_count !== 3'd0 || rd_if.rd_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_empty got count %0d valid %b expected 0 0", rd_if.fifo_count, rd_if.rd_valid); end
    endtask

    task automatic test_glitch();
        $display("glitch 5 clk low");
        rx = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        n_checks++; if (rd_if.fifo_count !== 3'd0) begin n_fail++; $display("FAIL glitch_count got %0d expected 0", rd_if.fifo_count); end
        n_checks++; if ({rd_if.frame_err, rd_if.overrun} !== 2'b00) begin n_fail++; $display("FAIL glitch_errs got %b expected 00", {rd_if.frame_err, rd_if.overrun}); end
    endtask

    task automatic test_frame_err();
        logic [7:0] b;
        send_frame(8'h3C, 40);
        repeat (20) @(posedge clk);
        #1;
        n_checks++; if (rd_if.frame_err !== 1'b1) begin n_fail++; $display("FAIL ferr_set got %b expected 1", rd_if.frame_err); end
        n_checks++; if (rd_if.fifo_count !== 3'd0) begin n_fail++; $display("FAIL ferr_count got %0d expected 0", rd_if.fifo_count); end
        send_frame(8'h81, 0);
        n_checks++; if (rd_if.fifo_count !== 3'd1 || rd_if.rd_data !== 8'h81) begin n_fail++; $display("FAIL ferr_recover got count %0d data %h expected 1 81", rd_if.fifo_count, rd_if.rd_data); end
        n_checks++; if (rd_if.frame_err !== 1'b1) begin n_fail++; $display("FAIL ferr_sticky got %b expected 1", rd_if.frame_err); end
        pop_one(b);
        pulse_err_clr();
        n_checks++; if (rd_if.frame_err !== 1'b0) begin n_fail++; $display("FAIL ferr_clear got %b expected 0", rd_if.frame_err); end
    endtask

    task automatic test_overrun();
        logic [7:0] b;
        for (int i = 0; i < 5; i++) send_frame(8'h10 + 8'(i), 0);
        n_checks++; if (rd_if.fifo_count !== 3'd4) begin n_fail++; $display("FAIL ovr_count got %0d expected 4", rd_if.fifo_count); end
        n_checks++; if (rd_if.overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag got %b expected 1", rd_if.overrun); end
        n_checks++; if (rd_if.frame_err !== 1'b0) begin n_fail++; $display("FAIL ovr_ferr got %b expected 0", rd_if.frame_err); end
        for (int i = 0; i < 4; i++) begin
            pop_one(b);
            n_checks++; if (b !== 8'h10 + 8'(i)) begin n_fail++; $display("FAIL ovr_data%0d got %h expected %h", i, b, 8'h10 + 8'(i)); end
        end
        n_checks++; if (rd_if.fifo_count !== 3'd0) begin n_fail++; $display("FAIL ovr_drain got %0d expected 0", rd_if.fifo_count); end
        pulse_err_clr();
        n_checks++; if (rd_if.overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear got %b expected 0", rd_if.overrun); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] b;
        for (int i = 0; i < 4; i++) send_frame(8'h20 + 8'(i), 0);
        n_checks++; if (rd_if.fifo_count !== 3'd4) begin n_fail++; $display("FAIL fpp_fill got %0d expected 4", rd_if.fifo_count); end
        pop_q.delete();
        fork
            send_frame(8'h24, 0);
            begin
                repeat (154) @(posedge clk);
                #1;
                rd_if.rd_ready = 1'b1;
                @(posedge clk);
                #1;
                rd_if.rd_ready = 1'b0;
            end
        join
        n_checks++; if (rd_if.fifo_count !== 3'd4) begin n_fail++; $display("FAIL fpp_count got %0d expected 4", rd_if.fifo_count); end
        n_checks++; if (rd_if.overrun !== 1'b0) begin n_fail++; $display("FAIL fpp_overrun got %b expected 0", rd_if.overrun); end
        n_checks++; if (pop_q.size() !== 1 || pop_q[0] !== 8'h20) begin n_fail++; $display("FAIL fpp_popped got size %0d head %h expected 1 20", pop_q.size(), (pop_q.size() > 0) ? pop_q[0] : 8'hxx); end
        for (int i = 0; i < 4; i++) begin
            pop_one(b);
            n_checks++; if (b !== 8'h21 + 8'(i)) begin n_fail++; $display("FAIL fpp_data%0d got %h expected %h", i, b, 8'h21 + 8'(i)); end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        send_frame(8'h42, 0);
        send_frame(8'h00, 16);
        repeat (10) @(posedge clk);
        #1;
        n_checks++; if (rd_if.fifo_count !== 3'd1 || rd_if.frame_err !== 1'b1) begin n_fail++; $display("FAIL rst_pre got count %0d ferr %b expected 1 1", rd_if.fifo_count, rd_if.frame_err); end
        $display("partial frame then reset");
        rx = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            rx = i[0];
            repeat (16) @(posedge clk);
            #1;
        end
        reset_n = 1'b0;
        rx = 1'b1;
        #2;
        n_checks++; if (rd_if.rd_valid !== 1'b0 || rd_if.rd_data !== 8'h00 || rd_if.fifo_count !== 3'd0) begin n_fail++; $display("FAIL rst_fifo got valid %b data %h count %0d expected 0 00 0", rd_if.rd_valid, rd_if.rd_data, rd_if.fifo_count); end
        n_checks++; if ({rd_if.frame_err, rd_if.overrun} !== 2'b00) begin n_fail++; $display("FAIL rst_errs got %b expected 00", {rd_if.frame_err, rd_if.overrun}); end
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        send_frame(8'h5A, 0);
        n_checks++; if (rd_if.fifo_count !== 3'd1 || rd_if.rd_data !== 8'h5A) begin n_fail++; $display("FAIL rst_after got count %0d data %h expected 1 5a", rd_if.fifo_count, rd_if.rd_data); end
        n_checks++; if ({rd_if.frame_err, rd_if.overrun} !== 2'b00) begin n_fail++; $display("FAIL rst_after_errs got %b expected 00", {rd_if.frame_err, rd_if.overrun}); end
        pop_one(b);
    endtask

    initial begin
        rd_if.rd_ready = 1'b0;
        rd_if.err_clr  = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_full_push_pop();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
UART receiver for the board's uart_rx pin, the receiving end of the MCU serial transmit path (8N1, LSB first). It synchronises the line, detects and validates start bits with 16x oversampling, and assembles bytes. Completed bytes go into a small FIFO that exposes a valid/ready read interface, for the MCU input ports or a program loader. It also reports sticky framing and overrun errors.

Parameters:
CLK_FREQUENCY, 50000000, system clock in Hz
BAUD_RATE, 115200, line rate in baud
FIFO_DEPTH, 4, byte entries; power of 2, >= 2
Derived constant TICK_DIV = round(CLK_FREQUENCY / (BAUD_RATE*16)), minimum 1 (27 at defaults)

Ports:
clk        input   1  system clock
reset_n    input   1  asynchronous, active-low reset
rx         input   1  raw serial line, idle high, asynchronous to clk
rd_data    output  8  byte at FIFO head; valid only while rd_valid=1
rd_valid   output  1  FIFO not empty
rd_ready   input   1  consumer pops the head when rd_valid & rd_ready
frame_err  output  1  sticky: stop bit sampled low
overrun    output  1  sticky: byte completed while FIFO full
err_clr    input   1  clears both sticky flags
fifo_count output  $clog2(FIFO_DEPTH)+1  current occupancy

Behaviour:
- Reset: all outputs 0. Synchroniser flops reset to 1 (idle). FSM in IDLE. FIFO empty. Reset mid-frame discards the partial byte.
- rx passes through a 2-flop synchroniser; the FSM uses only the synchronised value rx_s.
- Tick generator: counts 0..TICK_DIV-1 and pulses tick for 1 clk at wrap. Counter is held at 0 in IDLE, so phase aligns to the start edge.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH. Sample counter is 4 bits; bit counter is 3 bits.
  - IDLE: rx_s=0 -> START, sample counter cleared.
  - START: on the 8th tick (mid-bit) sample rx_s. Value 1 is a glitch -> IDLE. Value 0 -> DATA with the sample counter cleared.
  - DATA: every 16th tick sample rx_s into shift[bit], LSB first. After bit 7 -> STOP.
  - STOP: on the 16th tick sample rx_s.
    - Value 1 and FIFO not full: push shift in the same clk -> IDLE.
    - Value 1 and FIFO full: byte dropped, overrun<=1 -> IDLE.
    - Value 0: byte dropped, frame_err<=1 -> WAIT_HIGH.
  - WAIT_HIGH: stays until rx_s=1, then -> IDLE. This prevents a break condition from retriggering.
- Latency: rd_valid rises 1 clk after the stop-bit sampling clk (registered FIFO count).
- FIFO:
  - Circular buffer with rd/wr pointers one bit wider than the index; full = MSBs differ and index bits are equal.
  - rd_data is driven from mem[rd_ptr] (combinational read of a registered array).
  - Push and pop in the same clk: both happen and the count is unchanged. This holds when full too: the pop frees a slot, so the push is accepted and overrun is not set.
  - A pop while empty is ignored.
- Errors:
  - Setting a flag has priority over err_clr in the same clk.
  - err_clr does not affect FIFO contents or the FSM.
- Pointers wrap modulo FIFO_DEPTH; the count never exceeds FIFO_DEPTH.

Decomposition:
- Package uart_pkg:
  - state enum rx_state_t (IDLE, START, DATA, STOP, WAIT_HIGH)
  - constant OVERSAMPLE=16, DATA_BITS=8
  - function tick_div(clk, baud), clamped to >= 1
- Sub-module sync_fifo (parameters WIDTH, DEPTH): holds the buffer, pointers, count, full/empty and the simultaneous push/pop rules.
- uart_rx_fifo holds the synchroniser, tick generator, FSM, shifter and error flags.

Test Plan:
1. CLK_FREQUENCY=1600000, BAUD_RATE=100000 (TICK_DIV=1, 16 clk/bit), rd_ready=0; send frame 0x55 -> rd_valid=1 one clk after the stop sample, rd_data=0x55, fifo_count=1, no errors.
2. Send 0xA3, 0x00 and 0xFF back to back with rd_ready=1 -> three one-clk pops of A3, 00, FF in order; the FIFO ends empty.
3. Pull rx low for 5 clk, then high -> the FSM returns to IDLE at the mid-start sample, nothing is pushed, no error flags.
4. Send 0x3C with the stop bit held low, then release rx high after 40 clk -> frame_err=1, FIFO empty. Then send a good 0x81 -> it is received. Pulse err_clr -> frame_err=0.
5. With rd_ready=0, send 5 bytes 0x10..0x14 into a depth-4 FIFO -> fifo_count=4, overrun=1, the FIFO holds 10..13 and 0x14 is lost.
6. With the FIFO full, assert rd_ready on the same clk as a stop-bit push -> count stays 4, overrun stays 0. Separately, assert reset_n=0 mid-DATA -> all outputs go to 0 and the next clean frame is received correctly.
